uart_rx_flow_ctrl: RTL and testbench
====================================

Name: uart_rx_flow_ctrl

Overview:
- Receive-side flow controller for the UART.
- Accepts completed bytes from the UART RX core on rx_done and buffers them in a small show-ahead FIFO.
- Drives the RTS_n handshake from FIFO occupancy with high/low watermark hysteresis, so the remote transmitter is throttled before overrun.
- Sits between the RX core and the host/bus read port.
- rts_n is the signal checked against rx_done by the UART interface assertions.

Parameters:
DATA_W, 8, received byte width
DEPTH, 16, FIFO entries (power of two, >= 4)
HI_MARK, 12, occupancy at or above which rts_n deasserts (goes 1)
LO_MARK, 4, occupancy at or below which rts_n reasserts (goes 0); must satisfy LO_MARK < HI_MARK <= DEPTH

Ports:
clk  in  1  single clock, all logic on rising edge
rst  in  1  synchronous reset, active-high
rx_done  in  1  one-cycle pulse: byte complete on rx_data
rx_data  in  DATA_W  received byte, valid when rx_done=1
rx_frame_err  in  1  stop-bit error for the byte, qualified by rx_done
rd_en  in  1  host pop request
rd_data  out  DATA_W  FIFO head (show-ahead)
rd_valid  out  1  FIFO non-empty
count  out  $clog2(DEPTH)+1  current occupancy
rts_n  out  1  0 = ready to receive, 1 = stop sending
overrun  out  1  sticky: byte dropped because FIFO was full
ovr_clr  in  1  clears overrun
frame_err_cnt  out  8  saturating count of framing-error bytes

Behaviour:
- Reset (rst=1 at an edge):
  - count=0, rd_valid=0, rd_data=0, rts_n=1, overrun=0, frame_err_cnt=0.
  - Pointers cleared and FSM set to INIT.
  - Reset mid-operation discards all buffered bytes.
- FSM states: INIT, ALLOW, HOLD.
  - INIT: rts_n=1; unconditionally goes to ALLOW on the first edge after rst deasserts.
  - ALLOW: rts_n=0; goes to HOLD when next_count >= HI_MARK.
  - HOLD: rts_n=1; goes to ALLOW when next_count <= LO_MARK.
  - rts_n is a registered FSM output and changes on the same edge as count.
- Push accepted when rx_done=1, rx_frame_err=0, and (count<DEPTH or pop accepted in the same cycle).
- Pop accepted when rd_en=1 and count>0.
  - rd_en while empty is ignored; no underflow and no state change.
- next_count = count + push - pop. Simultaneous push and pop leaves count unchanged, including when count=DEPTH.
- Latency:
  - Byte pushed into an empty FIFO at edge N: rd_valid=1 and rd_data=byte after edge N.
  - After a pop at edge N, rd_data shows the next entry (or holds the last value with rd_valid=0).
- Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH; the FIFO is full when count=DEPTH.
- Full drop: rx_done=1, rx_frame_err=0, count=DEPTH and no pop → byte dropped, overrun set to 1 at that edge; FIFO contents unchanged.
- Overrun clear:
  - ovr_clr=1 clears overrun.
  - If an overrun event occurs in the same cycle as ovr_clr, set wins.
- Framing error:
  - rx_done=1 with rx_frame_err=1 → byte not stored.
  - frame_err_cnt increments, saturating at 255; it is not affected by ovr_clr.
- rx_done held high for multiple cycles is treated as one push per cycle. The RX core guarantees single-cycle pulses; no edge detection is done here.
- The hysteresis band is sticky:
  - Occupancy between LO_MARK and HI_MARK leaves the state unchanged.
  - A push/pop pair while at HI_MARK-1 does not toggle rts_n.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, release → cycle 1 rts_n=1 (INIT), cycle 2 rts_n=0, count=0, rd_valid=0.
- Fill: 12 rx_done pulses with data 0x01..0x0C, no reads → rts_n goes 1 on the edge where count becomes 12; rd_data=0x01.
- Drain with hysteresis: from count=12, pop one per cycle → rts_n stays 1 at counts 11..5 and goes 0 on the edge count becomes 4; popped data in order 0x01..0x08.
- Overflow: fill to 16 with 0x10..0x1F, push 0xAA with no pop → count=16, overrun=1, head still 0x10; push 0xBB with rd_en=1 → count=16, 0xBB stored at tail; ovr_clr=1 → overrun=0.
- Framing error: rx_done with rx_frame_err=1 three times on an empty FIFO → count=0, rd_valid=0, frame_err_cnt=3; 300 such pulses → frame_err_cnt=255.
- Reset mid-stream: count=9 with rts_n=0, assert rst for one cycle → count=0, rts_n=1, overrun=0, then rts_n=0 two cycles after release; rd_en while empty → count stays 0.

Source files
------------

// File: rtl/uart_rx_flow_ctrl.sv
// Receive-side flow controller for the UART.
// Completed bytes from the RX core go into a show-ahead FIFO.
// The RTS_n handshake follows FIFO occupancy, with high/low watermark
// hysteresis, so the remote transmitter is throttled before overrun.
module uart_rx_flow_ctrl #(
    parameter int DATA_W  = 8,
    parameter int DEPTH   = 16,
    parameter int HI_MARK = 12,
    parameter int LO_MARK = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     rx_done,
    input  logic [DATA_W-1:0]        rx_data,
    input  logic                     rx_frame_err,
    input  logic                     rd_en,
    output logic [DATA_W-1:0]        rd_data,
    output logic                     rd_valid,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     rts_n,
    output logic                     overrun,
    input  logic                     ovr_clr,
    output logic [7:0]               frame_err_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_ALLOW = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic [CW-1:0]     keep_s;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic              rd_valid_q;
    logic              overrun_q, overrun_d;
    logic [7:0]        fec_q, fec_d;
    logic              full_s, push_s, pop_s, drop_s, ferr_s;
    state_t            state_q;
    logic              rts_n_q;

    // Accept/drop decisions, next occupancy, pointers and next head byte
    always_comb begin
        full_s   = (count_q == CW'(DEPTH));
        pop_s    = rd_en && (count_q != {CW{1'b0}});
        push_s   = rx_done && !rx_frame_err && (!full_s || pop_s);
        drop_s   = rx_done && !rx_frame_err && full_s && !pop_s;
        ferr_s   = rx_done && rx_frame_err;
        count_d  = count_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_s && !pop_s) begin
            count_d = count_q + CW'(1'b1);
        end else if (pop_s && !push_s) begin
            count_d = count_q - CW'(1'b1);
        end else begin
            count_d = count_q;
        end
        if (push_s) begin
            wr_ptr_d = wr_ptr_q + AW'(1'b1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + AW'(1'b1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        // Entries already stored that survive this edge; if none, the
        // incoming byte (if any) becomes the new head directly.
        keep_s = count_q - {{(CW-1){1'b0}}, pop_s};
        if (keep_s != {CW{1'b0}}) begin
            rd_data_d = mem_q[rd_ptr_d];
        end else if (push_s) begin
            rd_data_d = rx_data;
        end else begin
            rd_data_d = rd_data_q;
        end
        // An overrun in the same cycle as a clear keeps the flag set
        if (drop_s) begin
            overrun_d = 1'b1;
        end else if (ovr_clr) begin
            overrun_d = 1'b0;
        end else begin
            overrun_d = overrun_q;
        end
        if (ferr_s && (fec_q != 8'hFF)) begin
            fec_d = fec_q + 8'd1;
        end else begin
            fec_d = fec_q;
        end
    end

    // FIFO storage write; contents need no reset since occupancy gates reads
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= rx_data;
        end
    end

    // Pointers, occupancy, head register and status flags
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= {AW{1'b0}};
            rd_ptr_q   <= {AW{1'b0}};
            count_q    <= {CW{1'b0}};
            rd_data_q  <= {DATA_W{1'b0}};
            rd_valid_q <= 1'b0;
            overrun_q  <= 1'b0;
            fec_q      <= 8'd0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= (count_d != {CW{1'b0}});
            overrun_q  <= overrun_d;
            fec_q      <= fec_d;
        end
    end

    // RTS hysteresis FSM; rts_n updates on the same edge as occupancy
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_INIT;
            rts_n_q <= 1'b1;
        end else begin
            case (state_q)
                ST_INIT: begin
                    state_q <= ST_ALLOW;
                    rts_n_q <= 1'b0;
                end
                ST_ALLOW: begin
                    if (count_d >= CW'(HI_MARK)) begin
                        state_q <= ST_HOLD;
                        rts_n_q <= 1'b1;
                    end else begin
                        state_q <= ST_ALLOW;
                        rts_n_q <= 1'b0;
                    end
                end
                ST_HOLD: begin
                    if (count_d <= CW'(LO_MARK)) begin
                        state_q <= ST_ALLOW;
                        rts_n_q <= 1'b0;
                    end else begin
                        state_q <= ST_HOLD;
                        rts_n_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_INIT;
                    rts_n_q <= 1'b1;
                end
            endcase
        end
    end

    assign rd_data       = rd_data_q;
    assign rd_valid      = rd_valid_q;
    assign count         = count_q;
    assign rts_n         = rts_n_q;
    assign overrun       = overrun_q;
    assign frame_err_cnt = fec_q;

endmodule

// File: tb/tb_uart_rx_flow_ctrl.sv
// Scoreboard bench for uart_rx_flow_ctrl: accepted bytes are queued at
// issue time, and a negedge monitor compares each popped head byte.
module tb_uart_rx_flow_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx_done;
    logic [7:0] rx_data;
    logic       rx_frame_err;
    logic       rd_en;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic [4:0] count;
    logic       rts_n;
    logic       overrun;
    logic       ovr_clr;
    logic [7:0] frame_err_cnt;

    int vectors    = 0;
    int miscompares = 0;
    logic [7:0] exp_q [$];

    uart_rx_flow_ctrl #(.DATA_W(8), .DEPTH(16), .HI_MARK(12), .LO_MARK(4)) dut (
        .clk           (clk),
        .rst           (rst),
        .rx_done       (rx_done),
        .rx_data       (rx_data),
        .rx_frame_err  (rx_frame_err),
        .rd_en         (rd_en),
        .rd_data       (rd_data),
        .rd_valid      (rd_valid),
        .count         (count),
        .rts_n         (rts_n),
        .overrun       (overrun),
        .ovr_clr       (ovr_clr),
        .frame_err_cnt (frame_err_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
                     name, act, act, exp, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one byte on rx_done; queue it when the bench expects acceptance
    task automatic drive_byte(input logic [7:0] d, input bit accept);
        rx_done      = 1'b1;
        rx_frame_err = 1'b0;
        rx_data      = d;
        if (accept) exp_q.push_back(d);
    endtask

    task automatic idle_in();
        rx_done      = 1'b0;
        rx_frame_err = 1'b0;
        rd_en        = 1'b0;
        ovr_clr      = 1'b0;
    endtask

    // Monitor: every accepted pop is checked against the scoreboard head
    always @(negedge clk) begin
        if (!rst && rd_en && rd_valid) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL pop_unexpected: got 0x%0h, expected no data", rd_data);
            end else begin
                chk("pop_data", int'(rd_data), int'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        rst = 1'b1;
        rx_data = 8'h00;
        idle_in();
        tick();
        tick();
        chk("rst_count", count, 0);
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_rd_data", rd_data, 0);
        chk("rst_rts_n", rts_n, 1);
        chk("rst_overrun", overrun, 0);
        chk("rst_fec", frame_err_cnt, 0);
        rst = 1'b0;
        #2;
        chk("init_rts_n", rts_n, 1);
        tick();
        chk("allow_rts_n", rts_n, 0);
        chk("idle_count", count, 0);
        chk("idle_rd_valid", rd_valid, 0);

        // Fill 0x01..0x0C: rts_n rises on the edge count reaches 12
        for (int i = 1; i <= 12; i++) begin
            drive_byte(8'(i), 1'b1);
            tick();
            chk("fill_count", count, i);
            chk("fill_rts_n", rts_n, (i >= 12) ? 1 : 0);
        end
        idle_in();
        chk("fill_head", rd_data, 8'h01);
        chk("fill_valid", rd_valid, 1);

        // Drain 8: rts_n stays high down to 5, drops when count hits 4
        for (int k = 0; k < 8; k++) begin
            rd_en = 1'b1;
            tick();
            chk("drain_count", count, 11 - k);
            chk("drain_rts_n", rts_n, ((11 - k) <= 4) ? 0 : 1);
        end
        for (int k = 0; k < 4; k++) begin
            rd_en = 1'b1;
            tick();
        end
        idle_in();
        chk("empty_count", count, 0);
        chk("empty_valid", rd_valid, 0);
        chk("empty_hold_data", rd_data, 8'h0C);

        // Overflow: fill 16 with 0x10..0x1F
        for (int i = 0; i < 16; i++) begin
            drive_byte(8'h10 + 8'(i), 1'b1);
            tick();
        end
        idle_in();
        chk("full_count", count, 16);
        chk("full_rts_n", rts_n, 1);
        drive_byte(8'hAA, 1'b0);
        tick();
        idle_in();
        chk("drop_count", count, 16);
        chk("drop_overrun", overrun, 1);
        chk("drop_head", rd_data, 8'h10);
        drive_byte(8'hBB, 1'b1);
        rd_en = 1'b1;
        tick();
        idle_in();
        chk("pushpop_full_count", count, 16);
        chk("pushpop_full_head", rd_data, 8'h11);
        chk("overrun_sticky", overrun, 1);
        ovr_clr = 1'b1;
        tick();
        idle_in();
        chk("ovr_clr", overrun, 0);
        // Set wins over clear in the same cycle
        drive_byte(8'hCC, 1'b0);
        ovr_clr = 1'b1;
        tick();
        idle_in();
        chk("ovr_set_wins", overrun, 1);
        ovr_clr = 1'b1;
        tick();
        idle_in();
        chk("ovr_clr2", overrun, 0);
        for (int k = 0; k < 16; k++) begin
            rd_en = 1'b1;
            tick();
        end
        idle_in();
        chk("ovf_drain_count", count, 0);
        chk("ovf_drain_rts_n", rts_n, 0);
        chk("ovf_last_data", rd_data, 8'hBB);
        rd_en = 1'b1;
        tick();
        idle_in();
        chk("underflow_count", count, 0);
        chk("underflow_valid", rd_valid, 0);

        // Framing errors: bytes discarded, counter saturates at 255
        for (int i = 0; i < 3; i++) begin
            rx_done = 1'b1;
            rx_frame_err = 1'b1;
            rx_data = 8'h55;
            tick();
        end
        idle_in();
        chk("ferr_count", count, 0);
        chk("ferr_valid", rd_valid, 0);
        chk("ferr_cnt3", frame_err_cnt, 3);
        for (int i = 0; i < 300; i++) begin
            rx_done = 1'b1;
            rx_frame_err = 1'b1;
            tick();
        end
        idle_in();
        chk("ferr_sat", frame_err_cnt, 255);

        // Hysteresis band: push/pop pair at HI_MARK-1 keeps rts_n low
        for (int i = 0; i < 11; i++) begin
            drive_byte(8'h40 + 8'(i), 1'b1);
            tick();
        end
        idle_in();
        chk("band_count", count, 11);
        chk("band_rts_n", rts_n, 0);
        drive_byte(8'h4B, 1'b1);
        rd_en = 1'b1;
        tick();
        idle_in();
        chk("band_pp_count", count, 11);
        chk("band_pp_rts_n", rts_n, 0);
        rd_en = 1'b1;
        tick();
        tick();
        idle_in();
        chk("mid_count", count, 9);
        chk("mid_rts_n", rts_n, 0);

        // Reset mid-stream discards buffered bytes
        rst = 1'b1;
        exp_q.delete();
        tick();
        rst = 1'b0;
        chk("mrst_count", count, 0);
        chk("mrst_rts_n", rts_n, 1);
        chk("mrst_overrun", overrun, 0);
        chk("mrst_valid", rd_valid, 0);
        chk("mrst_fec", frame_err_cnt, 0);
        tick();
        chk("mrst_allow", rts_n, 0);
        rd_en = 1'b1;
        tick();
        idle_in();
        chk("mrst_underflow", count, 0);
        chk("mrst_underflow_v", rd_valid, 0);

        tick();
        chk("sb_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
